// File: rtl/fp_alu_pkg.sv
// Shared definitions for the two-requester FP ALU front end: default widths,
// op encodings and the in-flight tag layout.
package fp_alu_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ALU_LAT_DEF = 2;
  localparam int unsigned OP_W        = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } fp_op_e;

  // One entry of the latency-matching pipeline: was an op issued, and by whom.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the priority pointer
// moves to the losing side whenever a grant is given.
module rr_arb2
  import fp_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant is suppressed while in reset so nothing issues from a half-reset state.
  always_comb begin
    grant_o = 2'b00;
    ptr_d   = ptr_q;
    if (rst_n) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
    if (|grant_o) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fp_alu_arbiter.sv
// Shares one fixed-latency FP ALU between two requesters; a tag shift register
// matches the ALU latency so each result is steered back to its issuer.
module fp_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ALU_LAT = ALU_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][DATA_W-1:0] req_para1,
  input  logic [1:0][DATA_W-1:0] req_para2,
  input  logic [1:0][OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]      alu_para1,
  output logic [DATA_W-1:0]      alu_para2,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_under_overflow,
  input  logic                   alu_zero,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_under_overflow,
  output logic                   rsp_zero,
  output logic                   busy
);

  logic [1:0] grant;
  logic       hs;
  logic       gid;
  tag_t       tag_q [ALU_LAT];
  tag_t       tag_d [ALU_LAT];
  tag_t       out_tag;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (req_valid),
    .grant_o (grant)
  );

  assign req_ready = grant;

  // Operand mux toward the ALU; idle cycles present a reserved op on zero operands.
  always_comb begin
    hs        = |grant;
    gid       = grant[1];
    alu_para1 = '0;
    alu_para2 = '0;
    alu_op    = OP_W'(OP_RSVD);
    if (hs) begin
      alu_para1 = req_para1[gid];
      alu_para2 = req_para2[gid];
      alu_op    = req_op[gid];
    end
  end

  always_comb begin
    tag_d[0] = '{valid: hs, id: gid};
    for (int unsigned i = 1; i < ALU_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ALU_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < ALU_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign out_tag = tag_q[ALU_LAT-1];

  // The ALU result lines up with the oldest tag, so responses pass straight through.
  always_comb begin
    rsp_valid              = 2'b00;
    rsp_valid[out_tag.id]  = out_tag.valid;
    busy                   = 1'b0;
    for (int unsigned i = 0; i < ALU_LAT; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

  assign rsp_data           = alu_out;
  assign rsp_under_overflow = alu_under_overflow;
  assign rsp_zero           = alu_zero;

endmodule

// File: tb/tb_fp_alu_arbiter.sv
// Directed and random stimulus against a stand-in fixed-latency ALU, with a
// response scoreboard and a reference round-robin model.
module tb_fp_alu_arbiter;
  import fp_alu_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0][DW-1:0] req_para1;
  logic [1:0][DW-1:0] req_para2;
  logic [1:0][1:0]    req_op;
  logic [DW-1:0]      alu_para1, alu_para2, alu_out;
  logic [1:0]         alu_op;
  logic               alu_uov, alu_zero;
  logic [1:0]         rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_uov, rsp_zero, busy;

  typedef struct {
    int unsigned due;
    logic        id;
    logic [33:0] res;
  } exp_t;

  exp_t        q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  logic        ptr_m = 1'b0;
  logic [33:0] alu_pipe [LAT];

  always #5 clk = ~clk;

  fp_alu_arbiter #(.DATA_W(DW), .ALU_LAT(LAT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_para1          (req_para1),
    .req_para2          (req_para2),
    .req_op             (req_op),
    .alu_para1          (alu_para1),
    .alu_para2          (alu_para2),
    .alu_op             (alu_op),
    .alu_out            (alu_out),
    .alu_under_overflow (alu_uov),
    .alu_zero           (alu_zero),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .rsp_under_overflow (rsp_uov),
    .rsp_zero           (rsp_zero),
    .busy               (busy)
  );

  // Stand-in ALU: known FP cases return real encodings, anything else a cheap integer mix.
  function automatic logic [33:0] fake_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      2'b00:   r = (a == 32'h3F80_0000 && b == 32'h4000_0000) ? 32'h4040_0000 : a + b;
      2'b01:   r = a - b;
      2'b10:   r = (a == 32'h4000_0000 && b == 32'h4040_0000) ? 32'h40C0_0000 : a * b;
      default: r = '0;
    endcase
    return {(op != 2'b11) && (r[31:30] == 2'b11), (r == '0), r};
  endfunction

  always @(posedge clk) begin
    alu_pipe[0] <= fake_alu(alu_op, alu_para1, alu_para2);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {alu_uov, alu_zero, alu_out} = alu_pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Reference arbiter and scoreboard, evaluated mid-cycle when everything is settled.
  always @(negedge clk) begin
    logic [1:0] g;
    logic [1:0] onehot;
    logic       id;
    logic       busy_exp;
    exp_t       e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      ptr_m = 1'b0;
      chk("ready_in_reset", 64'(req_ready), 64'(0));
      chk("rsp_in_reset", 64'(rsp_valid), 64'(0));
      chk("busy_in_reset", 64'(busy), 64'(0));
    end else begin
      busy_exp = (q.size() > 0) && (q[0].due <= cyc + 1);
      chk("busy", 64'(busy), 64'(busy_exp));
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        onehot = 2'b00;
        onehot[e.id] = 1'b1;
        chk("rsp_valid", 64'(rsp_valid), 64'(onehot));
        chk("rsp_data", 64'(rsp_data), 64'(e.res[31:0]));
        chk("rsp_zero", 64'(rsp_zero), 64'(e.res[32]));
        chk("rsp_uov", 64'(rsp_uov), 64'(e.res[33]));
      end else begin
        chk("rsp_idle", 64'(rsp_valid), 64'(0));
      end
      case (req_valid)
        2'b01:   g = 2'b01;
        2'b10:   g = 2'b10;
        2'b11:   g = ptr_m ? 2'b10 : 2'b01;
        default: g = 2'b00;
      endcase
      chk("req_ready", 64'(req_ready), 64'(g));
      id = g[1];
      if (g != 2'b00) begin
        chk("alu_op", 64'(alu_op), 64'(req_op[id]));
        chk("alu_para1", 64'(alu_para1), 64'(req_para1[id]));
        chk("alu_para2", 64'(alu_para2), 64'(req_para2[id]));
        e.due = cyc + LAT;
        e.id  = id;
        e.res = fake_alu(req_op[id], req_para1[id], req_para2[id]);
        q.push_back(e);
        ptr_m = g[0];
      end else begin
        chk("alu_idle_op", 64'(alu_op), 64'(2'b11));
        chk("alu_idle_para", 64'({alu_para1, alu_para2}), 64'(0));
      end
    end
  end

  task automatic set_req(input logic [1:0] v, input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req_valid    = v;
    req_op[0]    = op0;
    req_para1[0] = a0;
    req_para2[0] = b0;
    req_op[1]    = op1;
    req_para1[1] = a1;
    req_para2[1] = b1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    @(posedge clk);
    #1;
    set_req(v, op0, a0, b0, op1, a1, b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(2'b00, 2'b00, 0, 0, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // 1.0 + 2.0 from req0, issued in the very first cycle out of reset
    set_req(2'b01, 2'b00, 32'h3F80_0000, 32'h4000_0000, 2'b00, 0, 0);
    idle(3);
    // req1 alone for three cycles: 2.0 * 3.0, leaves the pointer on req0
    for (int i = 0; i < 3; i++) drive(2'b10, 2'b00, 0, 0, 2'b10, 32'h4000_0000, 32'h4040_0000);
    idle(3);
    // both valid for four cycles: grants must alternate starting at req0
    for (int i = 0; i < 4; i++)
      drive(2'b11, 2'b00, 32'h3F80_0000, 32'h4000_0000, 2'b01, 32'h1000 + 32'(i), 32'h10 + 32'(i));
    idle(3);
    // reserved op still produces a response
    drive(2'b01, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 2'b00, 0, 0);
    idle(3);
    // issue, then reset before the result returns; pointer must come back on req0
    drive(2'b01, 2'b00, 32'h0000_0100, 32'h0000_0200, 2'b00, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_req(2'b11, 2'b00, 1, 2, 2'b01, 3, 4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 5, 6, 2'b01, 7, 8);
    idle(4);
    // random traffic
    for (int i = 0; i < 10000; i++)
      drive(2'($urandom), 2'($urandom), $urandom, $urandom, 2'($urandom), $urandom, $urandom);
    idle(1);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
